// File: rtl/pattern_prbs_gen_pkg.sv
// Shared types and constants for the sync-word + PRBS-15 stream generator.
package pattern_prbs_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PATTERN = 2'd1,
      ST_PRBS    = 2'd2
   } state_e;

   localparam logic [14:0] PRBS15_SEED    = 15'h7FFF;
   localparam int          PRBS15_TAP_A   = 14;
   localparam int          PRBS15_TAP_B   = 13;
   localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/prbs15_byte_lfsr.sv
// PRBS-15 (x^15 + x^14 + 1) generator advancing eight bit-steps per step.
// byte_o always shows the byte the next step will produce, first bit in [0].
module prbs15_byte_lfsr
   import pattern_prbs_gen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [7:0] byte_o
);

   logic [14:0] lfsr_q;
   logic [14:0] lfsr_d;
   logic [14:0] walk;
   logic        nb;

   // Unroll eight serial LFSR steps to get the next byte and the state after it.
   always_comb begin
      walk   = lfsr_q;
      nb     = 1'b0;
      byte_o = 8'h00;
      for (int i = 0; i < 8; i++) begin
         nb        = walk[PRBS15_TAP_A] ^ walk[PRBS15_TAP_B];
         byte_o[i] = nb;
         walk      = {walk[13:0], nb};
      end
      lfsr_d = walk;
   end

   // LFSR state register; only moves when the byte is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= PRBS15_SEED;
      end else if (step) begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/pattern_prbs_gen.sv
// Byte stream source: n repetitions of a 32-bit sync word (LSB byte first)
// followed by an endless PRBS-15 payload, one byte per enabled clock.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for first enable; latches pattern/n on that edge
// ST_PATTERN | emitting sync-word bytes; fin_q marks the last one is out
// ST_PRBS    | emitting PRBS-15 bytes until reset
module pattern_prbs_gen
   import pattern_prbs_gen_pkg::*;
#(
   parameter int N_DEF = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] pattern,
   input  logic [7:0]  n,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        pattern_done
);

   localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  rep_q, rep_d;
   logic [31:0] pat_q, pat_d;
   logic [7:0]  n_q, n_d;
   logic        fin_q, fin_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic        lfsr_step;
   logic [7:0]  prbs_byte;

   prbs15_byte_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .step   (lfsr_step),
      .byte_o (prbs_byte)
   );

   // Next-state and output byte selection; everything holds when enable is low.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rep_d     = rep_q;
      pat_d     = pat_q;
      n_d       = n_q;
      fin_d     = fin_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      lfsr_step = 1'b0;
      if (enable) begin
         valid_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               pat_d = pattern;
               n_d   = n;
               rep_d = 8'd0;
               fin_d = 1'b0;
               if (n == 8'd0) begin
                  byte_d    = prbs_byte;
                  lfsr_step = 1'b1;
                  idx_d     = 2'd0;
                  state_d   = ST_PRBS;
               end else begin
                  byte_d  = pattern[7:0];
                  idx_d   = 2'd1;
                  state_d = ST_PATTERN;
               end
            end
            ST_PATTERN: begin
               if (fin_q) begin
                  // Last sync byte already went out: payload starts with no gap.
                  byte_d    = prbs_byte;
                  lfsr_step = 1'b1;
                  fin_d     = 1'b0;
                  state_d   = ST_PRBS;
               end else begin
                  byte_d = pat_q[{idx_q, 3'b000} +: 8];
                  fin_d  = (idx_q == IDX_LAST) && (rep_q == n_q - 8'd1);
                  if (idx_q == IDX_LAST) begin
                     idx_d = 2'd0;
                     rep_d = rep_q + 8'd1;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
            ST_PRBS: begin
               byte_d    = prbs_byte;
               lfsr_step = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, latched configuration and the registered output byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         rep_q   <= 8'd0;
         pat_q   <= 32'd0;
         n_q     <= 8'd0;
         fin_q   <= 1'b0;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         pat_q   <= pat_d;
         n_q     <= n_d;
         fin_q   <= fin_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
      end
   end

   assign byte_out     = byte_q;
   assign byte_valid   = valid_q;
   assign pattern_done = (state_q == ST_PRBS);

endmodule

// File: tb/tb_pattern_prbs_gen.sv
// Bench for pattern_prbs_gen: stream model indexed by byte count, per-cycle
// compare on the falling edge, plus literal spot checks on captured bytes.
module tb_pattern_prbs_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] pattern = 32'd0;
   logic [7:0]  n = 8'd0;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        pattern_done;

   int checks = 0;
   int errors = 0;

   pattern_prbs_gen #(.N_DEF(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .pattern      (pattern),
      .n            (n),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .pattern_done (pattern_done)
   );

   always #5 clk = ~clk;

   // Model: stream position k, config captured at the first enabled edge.
   logic [7:0]  prbs_tab [0:63];
   int          k = 0;
   logic [31:0] m_pat = 32'd0;
   int          m_n = 0;
   logic [7:0]  m_byte = 8'h00;
   logic        m_valid = 1'b0;

   function automatic logic [7:0] stream_byte(int idx);
      logic [31:0] w;
      if (idx < 4 * m_n) begin
         w = m_pat >> (8 * (idx % 4));
         return w[7:0];
      end
      if (idx - 4 * m_n > 63) return 8'hxx;
      return prbs_tab[idx - 4 * m_n];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         k = 0; m_pat = 32'd0; m_n = 0; m_byte = 8'h00; m_valid = 1'b0;
      end else if (enable) begin
         if (k == 0) begin
            m_pat = pattern;
            m_n   = int'(n);
         end
         m_byte  = stream_byte(k);
         k       = k + 1;
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      chk("byte_valid", {31'd0, byte_valid}, {31'd0, m_valid});
      chk("byte_out", {24'd0, byte_out}, {24'd0, m_byte});
      chk("pattern_done", {31'd0, pattern_done}, {31'd0, (k >= 4 * m_n + 1)});
   end

   // Capture emitted bytes and the pattern_done seen alongside each.
   logic [7:0] cap_b [$];
   logic       cap_d [$];
   always @(negedge clk) begin
      if (byte_valid) begin
         cap_b.push_back(byte_out);
         cap_d.push_back(pattern_done);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic restart(input logic [31:0] p, input logic [7:0] nn);
      tick();
      rst = 1'b0;
      enable = 1'b0;
      tick();
      tick();
      cap_b.delete();
      cap_d.delete();
      pattern = p;
      n = nn;
      rst = 1'b1;
   endtask

   task automatic run(input int cycles);
      enable = 1'b1;
      repeat (cycles) tick();
      enable = 1'b0;
      tick();
   endtask

   task automatic chk_cap(input string name, input int i, input logic [7:0] exp);
      if (i >= cap_b.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: byte %0d not captured (only %0d), expected %0h", name, i, cap_b.size(), exp);
      end else begin
         chk(name, {24'd0, cap_b[i]}, {24'd0, exp});
      end
   endtask

   initial begin
      logic [14:0] s;
      logic        nb;
      s = 15'h7FFF;
      for (int j = 0; j < 64; j++) begin
         for (int b = 0; b < 8; b++) begin
            nb = s[14] ^ s[13];
            prbs_tab[j][b] = nb;
            s = {s[13:0], nb};
         end
      end

      // Reset state
      tick();
      chk("reset byte_out", {24'd0, byte_out}, 32'd0);
      chk("reset valid", {31'd0, byte_valid}, 32'd0);
      chk("reset done", {31'd0, pattern_done}, 32'd0);
      chk("model prbs0", {24'd0, prbs_tab[0]}, 32'h00);
      chk("model prbs1", {24'd0, prbs_tab[1]}, 32'h40);

      // Basic run, n=4
      restart(32'h3ACF491E, 8'd4);
      run(20);
      chk("A cap count", cap_b.size(), 32'd20);
      chk_cap("A b0", 0, 8'h1E);
      chk_cap("A b1", 1, 8'h49);
      chk_cap("A b2", 2, 8'hCF);
      chk_cap("A b15", 15, 8'h3A);
      chk_cap("A b16", 16, 8'h00);
      chk_cap("A b17", 17, 8'h40);
      if (cap_d.size() >= 17) begin
         chk("A done b15", {31'd0, cap_d[15]}, 32'd0);
         chk("A done b16", {31'd0, cap_d[16]}, 32'd1);
      end

      // n=0: payload immediately
      restart(32'h3ACF491E, 8'd0);
      run(3);
      chk_cap("B b0", 0, 8'h00);
      chk_cap("B b1", 1, 8'h40);
      if (cap_d.size() >= 1) chk("B done b0", {31'd0, cap_d[0]}, 32'd1);

      // Stalls during PATTERN
      restart(32'h3ACF491E, 8'd4);
      for (int r = 0; r < 6; r++) begin
         enable = 1'b1; tick();
         enable = 1'b0; tick();
         tick();
         enable = 1'b1; tick();
      end
      enable = 1'b0; tick();
      chk("C cap count", cap_b.size(), 32'd12);
      chk_cap("C b4", 4, 8'h1E);
      chk_cap("C b7", 7, 8'h3A);

      // Async reset mid-PATTERN after 6 bytes
      restart(32'h3ACF491E, 8'd4);
      enable = 1'b1;
      repeat (6) tick();
      @(posedge clk);
      #2;
      rst = 1'b0;
      enable = 1'b0;
      #1;
      chk("D async byte_out", {24'd0, byte_out}, 32'd0);
      chk("D async valid", {31'd0, byte_valid}, 32'd0);
      chk("D async done", {31'd0, pattern_done}, 32'd0);
      tick();
      cap_b.delete();
      cap_d.delete();
      rst = 1'b1;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      chk_cap("D restart b0", 0, 8'h1E);

      // Config change after latch is ignored; n=1 boundary
      restart(32'h3ACF491E, 8'd1);
      enable = 1'b1;
      tick();
      pattern = 32'hFFFFFFFF;
      n = 8'd0;
      repeat (8) tick();
      enable = 1'b0;
      tick();
      chk_cap("E b1", 1, 8'h49);
      chk_cap("E b3", 3, 8'h3A);
      chk_cap("E b4", 4, 8'h00);
      chk_cap("E b5", 5, 8'h40);

      // n=255: 1020 sync bytes
      restart(32'h3ACF491E, 8'd255);
      run(1024);
      chk_cap("F b1019", 1019, 8'h3A);
      chk_cap("F b1020", 1020, 8'h00);
      chk_cap("F b1021", 1021, 8'h40);

      // Random enable, n=2
      restart(32'hA55A0FF0, 8'd2);
      for (int c = 0; c < 80; c++) begin
         enable = 1'($urandom_range(0, 1));
         tick();
      end
      enable = 1'b0;
      tick();
      chk_cap("G b0", 0, 8'hF0);
      chk_cap("G b3", 3, 8'hA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_prbs_gen.md
PATTERN_PRBS_GEN -- requirements
Module: pattern_prbs_gen

Interface
REQ-001 SHALL have parameter N_DEF, default 4: repeat count used when n input is 8'h00 is NOT substituted (see REQ-012); reserved for bench defaults only.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port enable  input  1  advance the stream one byte per clock when high.
REQ-005 SHALL have port pattern  input  32  sync word, sent LSB byte first.
REQ-006 SHALL have port n  input  8  number of sync-word repetitions before the PRBS payload.
REQ-007 SHALL have port byte_out  output  8  registered stream byte, matches the Pattern_Detector byte_in format.
REQ-008 SHALL have port byte_valid  output  1  high for exactly the cycles in which byte_out carries a new byte.
REQ-009 SHALL have port pattern_done  output  1  high while in PRBS state.

Function
REQ-010 SHALL implement FSM states IDLE, PATTERN, PRBS; encoding is free.
REQ-011 IDLE, enable=1 at an edge: latch pattern and n into internal registers, emit pattern[7:0] on that same edge, set byte index to 1 and rep count to 0, and go to PATTERN.
REQ-012 IDLE with n=0: go directly to PRBS and emit the first PRBS byte on that edge.
REQ-013 PATTERN, enable=1: emit latched_pattern[8*idx+7 -: 8], idx wraps 3->0, rep increments on wrap.
REQ-014 The final byte of repetition n (idx=3, rep=n-1) SHALL be followed, on the next enabled edge, by the first PRBS byte; no gap cycle is allowed.
REQ-015 PRBS SHALL be PRBS-15, x^15+x^14+1, with 15-bit state s and seed 15'h7FFF; per bit: nb = s[14]^s[13], s <= {s[13:0], nb}.
REQ-016 Each PRBS byte SHALL be 8 consecutive nb values, first generated bit in byte_out[0]; 8 bit-steps per enabled clock.
REQ-017 PRBS SHALL continue indefinitely until reset.
REQ-018 enable=0 in any state: byte_out holds, byte_valid=0, and idx, rep, LFSR and state are frozen.
REQ-019 Latency SHALL be 1 cycle: byte_valid=1 in the cycle after the edge that sampled enable=1.
REQ-020 Changes on pattern or n after the latch in REQ-011 SHALL be ignored until the next reset.
REQ-021 Arithmetic: rep is 8-bit; compare against latched n-1 with n>=1; n=255 SHALL produce 1020 sync bytes.

Reset
REQ-022 rst=0 SHALL immediately, with no clock required, force: state=IDLE, byte_out=8'h00, byte_valid=0, pattern_done=0, idx=0, rep=0, LFSR=15'h7FFF, latched pattern and n set to 0.
REQ-023 Reset asserted mid-PATTERN or mid-PRBS SHALL abort the stream; after release the sequence restarts from REQ-011.

Structure
REQ-024 A shared package SHALL hold the FSM state typedef, PRBS15_SEED=15'h7FFF, PRBS15 tap positions (14,13), and BYTES_PER_WORD=4.
REQ-025 SHALL instantiate one sub-module, prbs15_byte_lfsr: an 8-bit-per-step PRBS-15 generator with ports clk, rst, step, byte.

Verification
REQ-026 pattern=32'h3ACF491E, n=4, enable=1 continuously -> byte_out = 1E,49,CF,3A repeated 4x (16 bytes), then 00,40 as the first two PRBS bytes; pattern_done rises with byte 17.
REQ-027 Loopback: connect byte_out to Pattern_Detector byte_in, same pattern and n=4 -> pattern_valid=1 after the 16th byte.
REQ-028 n=0, enable=1 -> first byte 00, then 40; pattern_done=1 from the first enabled edge.
REQ-029 Toggle enable 1,0,0,1 during PATTERN -> byte_out holds across stalls, byte_valid=0 in stalls, no byte skipped or duplicated.
REQ-030 rst=0 pulsed after byte 6 of a run with n=4 -> outputs zero asynchronously; after release with enable=1 the next byte is 1E.
REQ-031 Change pattern to 32'hFFFFFFFF after the first byte -> stream still 1E,49,CF,3A for all repetitions.
